qei_sampler: RTL and testbench

QEI_SAMPLER -- requirements
Module: qei_sampler

---
 rtl/qei_sampler_pkg.sv | 19 +
 rtl/qei_sampler_counter.sv | 49 ++++
 rtl/qei_sampler.sv | 116 +++++++++++
 tb/tb_qei_sampler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qei_sampler_pkg.sv
// Shared definitions for the quadrature sampler: FSM encoding, default
// geometry and the channel-index width helper.
package qei_sampler_pkg;

  localparam int unsigned NCH_DEF    = 2;
  localparam int unsigned NBITS_DEF  = 16;
  localparam int unsigned PERIOD_DEF = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SEND
  } state_e;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qei_sampler_counter.sv
// x4 quadrature decoder and up/down position counter for one channel.
module qei_sampler_counter #(
  parameter int unsigned NBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             a_i,
  input  logic             b_i,
  output logic [NBITS-1:0] cnt_o
);

  logic             a_q;
  logic             b_q;
  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] cnt_d;
  logic             one_edge;
  logic             up;
  logic             dn;

  always_comb begin
    // exactly one phase toggled; a simultaneous double toggle is ignored
    one_edge = (a_i ^ a_q) ^ (b_i ^ b_q);
    up       = one_edge && (a_i ^ b_q);
    dn       = one_edge && (b_i ^ a_q);
    cnt_d    = cnt_q;
    if (en && up) begin
      cnt_d = cnt_q + NBITS'(1);
    end else if (en && dn) begin
      cnt_d = cnt_q - NBITS'(1);
    end
  end

  // History always follows the inputs (also on clear) so that motion seen
  // while disabled or cleared is never replayed as a step afterwards.
  always_ff @(posedge clk) begin
    a_q <= a_i;
    b_q <= b_i;
    if (rst || clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qei_sampler.sv
// Periodic snapshot of NCH quadrature counters, streamed out as one
// (channel, position, delta) beat per channel over a valid/ready handshake.
module qei_sampler
  import qei_sampler_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned NBITS  = NBITS_DEF,
  parameter int unsigned PERIOD = PERIOD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  clr_ovr,
  input  logic [NCH-1:0]        a_i,
  input  logic [NCH-1:0]        b_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ch_w(NCH)-1:0]  out_ch,
  output logic [NBITS-1:0]      out_pos,
  output logic [NBITS-1:0]      out_delta,
  output logic                  ovr
);

  localparam int unsigned CHW = ch_w(NCH);
  localparam int unsigned TW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [NBITS-1:0] cnt     [NCH];
  logic [NBITS-1:0] snap_q  [NCH];
  logic [NBITS-1:0] prev_q  [NCH];
  logic [NBITS-1:0] delta_q [NCH];
  logic [TW-1:0]    timer_q;
  logic [CHW-1:0]   idx_q;
  logic             valid_q;
  logic             ovr_q;
  state_e           state_q;
  logic             tick;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    qei_sampler_counter #(.NBITS(NBITS)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (en),
      .a_i   (a_i[g]),
      .b_i   (b_i[g]),
      .cnt_o (cnt[g])
    );
  end

  assign tick = en && (timer_q == TW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        snap_q[i]  <= '0;
        prev_q[i]  <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      if (en) begin
        timer_q <= (timer_q == TW'(PERIOD - 1)) ? '0 : timer_q + TW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (tick) state_q <= ST_SNAP;
        end
        ST_SNAP: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            snap_q[i]  <= cnt[i];
            delta_q[i] <= cnt[i] - prev_q[i];
            prev_q[i]  <= cnt[i];
          end
          idx_q   <= '0;
          valid_q <= 1'b1;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx_q == CHW'(NCH - 1)) begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + CHW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A tick arriving while a burst is pending is lost; setting beats clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (tick && !clr && (state_q != ST_IDLE)) begin
      ovr_q <= 1'b1;
    end else if (clr_ovr) begin
      ovr_q <= 1'b0;
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_ch    = idx_q;
    out_pos   = snap_q[idx_q];
    out_delta = delta_q[idx_q];
    ovr       = ovr_q;
  end

endmodule

// File: tb/tb_qei_sampler.sv
// Bench for qei_sampler: directed quadrature stimulus, a queue-based
// behavioural model checked every cycle, and literal beat expectations.
module tb_qei_sampler;

  localparam int NCH    = 2;
  localparam int NBITS  = 16;
  localparam int PERIOD = 10;

  logic             clk = 1'b0;
  logic             rst, en, clr, clr_ovr, out_ready;
  logic [NCH-1:0]   a_i, b_i;
  logic             out_valid, ovr;
  logic [0:0]       out_ch;
  logic [NBITS-1:0] out_pos, out_delta;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  qei_sampler #(.NCH(NCH), .NBITS(NBITS), .PERIOD(PERIOD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .clr_ovr   (clr_ovr),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_pos   (out_pos),
    .out_delta (out_delta),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Quadrature position 0..3 -> {A,B}: 00, 10, 11, 01 (A leads B going forward)
  function automatic int gray(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { int ch; int pos; int delta; } beat_t;
  beat_t mq[$];
  int    m_cnt[NCH], m_prev[NCH], m_g[NCH];
  int    m_timer = 0, m_start = 0, n_edge = 0;
  bit    m_ovr = 0, m_valid = 0, m_live = 0;
  logic  s_rst, s_en, s_clr, s_clr_ovr, s_ready;
  logic [NCH-1:0] s_a, s_b;

  always @(posedge clk) begin
    bit busy, tk;
    int st;
    s_rst = rst; s_en = en; s_clr = clr; s_clr_ovr = clr_ovr; s_ready = out_ready;
    s_a = a_i; s_b = b_i;
    #1;
    n_edge++;
    if (s_rst) m_live = 1;
    busy = (mq.size() != 0);
    tk   = s_en && (m_timer == PERIOD - 1);
    if (s_rst || s_clr) begin
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_prev[i] = 0; end
      m_timer = 0;
      mq.delete();
      if (s_rst || s_clr_ovr) m_ovr = 0;
    end else begin
      if (m_valid && s_ready) void'(mq.pop_front());
      for (int i = 0; i < NCH; i++) begin
        st = (gray(s_a[i], s_b[i]) - m_g[i] + 4) % 4;
        if (s_en && st == 1) m_cnt[i] = (m_cnt[i] + 1) & 16'hFFFF;
        if (s_en && st == 3) m_cnt[i] = (m_cnt[i] - 1) & 16'hFFFF;
      end
      if (tk && busy) m_ovr = 1;
      else if (s_clr_ovr) m_ovr = 0;
      if (tk && !busy) begin
        for (int i = 0; i < NCH; i++) begin
          mq.push_back('{ch: i, pos: m_cnt[i], delta: (m_cnt[i] - m_prev[i]) & 16'hFFFF});
          m_prev[i] = m_cnt[i];
        end
        m_start = n_edge + 1;
      end
      if (s_en) m_timer = (m_timer + 1) % PERIOD;
    end
    for (int i = 0; i < NCH; i++) m_g[i] = gray(s_a[i], s_b[i]);
    m_valid = (mq.size() != 0) && (n_edge >= m_start);
    if (m_live) begin
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_ovr", 32'(ovr), 32'(m_ovr));
      if (m_valid) begin
        chk("model_ch", 32'(out_ch), 32'(mq[0].ch));
        chk("model_pos", 32'(out_pos), 32'(mq[0].pos));
        chk("model_delta", 32'(out_delta), 32'(mq[0].delta));
      end
    end
  end

  // ---------------- stimulus ----------------
  int ph[NCH];

  task automatic move(input int d0, input int d1);
    int d[NCH];
    logic [1:0] ab;
    d[0] = d0; d[1] = d1;
    for (int i = 0; i < NCH; i++) begin
      ph[i] = (ph[i] + d[i] + 4) % 4;
      case (ph[i])
        0:       ab = 2'b00;
        1:       ab = 2'b10;
        2:       ab = 2'b11;
        default: ab = 2'b01;
      endcase
      a_i[i] = ab[1];
      b_i[i] = ab[0];
    end
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s: out_valid never rose within 60 cycles", nm);
    end
  endtask

  task automatic expect_beat(input string nm, input int ch, input int pos, input int dl);
    int k = 0;
    while (!(out_valid && out_ready) && k < 60) begin @(negedge clk); k++; end
    if (!(out_valid && out_ready)) begin
      checks++; errors++;
      $display("FAIL %s: no beat within 60 cycles", nm);
    end else begin
      chk({nm, "_ch"}, 32'(out_ch), 32'(ch));
      chk({nm, "_pos"}, 32'(out_pos), 32'(pos));
      chk({nm, "_delta"}, 32'(out_delta), 32'(dl));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1; en = 0; clr = 0; clr_ovr = 0; out_ready = 1;
    a_i = '0; b_i = '0;
    for (int i = 0; i < NCH; i++) ph[i] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ch", 32'(out_ch), 32'h0);
    chk("rst_pos", 32'(out_pos), 32'h0);
    chk("rst_delta", 32'(out_delta), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    en = 1;

    // ch0 +5, ch1 -3 before the first tick
    repeat (3) begin @(negedge clk); move(1, -1); end
    repeat (2) begin @(negedge clk); move(1, 0); end
    expect_beat("b1c0", 0, 5, 5);
    expect_beat("b1c1", 1, 16'hFFFD, 16'hFFFD);

    // stall 12 cycles, ch0 moves +2 during the stall
    wait_valid("stall");
    out_ready = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 2 || i == 4) move(1, 0);
    end
    chk("stall_ovr", 32'(ovr), 32'h1);
    chk("stall_ch", 32'(out_ch), 32'h0);
    chk("stall_pos", 32'(out_pos), 32'h5);
    chk("stall_delta", 32'(out_delta), 32'h0);
    out_ready = 1;
    expect_beat("b2c0", 0, 5, 0);
    expect_beat("b2c1", 1, 16'hFFFD, 0);
    expect_beat("b3c0", 0, 7, 2);
    expect_beat("b3c1", 1, 16'hFFFD, 0);

    // clr_ovr alone, then clr_ovr colliding with an overrun tick
    clr_ovr = 1; @(negedge clk); clr_ovr = 0;
    chk("clrovr_alone", 32'(ovr), 32'h0);
    wait_valid("ovr2");
    out_ready = 0;
    repeat (8) @(negedge clk);
    clr_ovr = 1; @(negedge clk); clr_ovr = 0;
    chk("clrovr_vs_set", 32'(ovr), 32'h1);
    out_ready = 1;
    repeat (4) @(negedge clk);
    clr_ovr = 1; @(negedge clk); clr_ovr = 0;
    chk("clrovr_again", 32'(ovr), 32'h0);

    // delta wrap in both directions
    clr = 1; @(negedge clk); clr = 0;
    repeat (2) begin @(negedge clk); move(-1, 0); end
    expect_beat("w0c0", 0, 16'hFFFE, 16'hFFFE);
    expect_beat("w0c1", 1, 0, 0);
    repeat (5) begin move(1, 0); @(negedge clk); end
    expect_beat("w1c0", 0, 16'h0003, 16'h0005);
    expect_beat("w1c1", 1, 0, 0);
    repeat (5) begin move(-1, 0); @(negedge clk); end
    expect_beat("w2c0", 0, 16'hFFFE, 16'hFFFB);
    expect_beat("w2c1", 1, 0, 0);

    // clr in the middle of a burst
    wait_valid("clrburst");
    clr = 1; @(negedge clk); clr = 0;
    chk("clr_valid", 32'(out_valid), 32'h0);
    expect_beat("c0", 0, 0, 0);
    expect_beat("c1", 1, 0, 0);

    // en low for 7 cycles starting inside a burst; ch1 edges ignored
    wait_valid("endly");
    t0 = cyc;
    en = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i <= 3) move(0, 1);
    end
    en = 1;
    wait_valid("endly2");
    chk("tick_delay", 32'(cyc - t0), 32'd17);
    expect_beat("e0", 0, 0, 0);
    expect_beat("e1", 1, 0, 0);

    // rst mid-burst
    wait_valid("rstburst");
    rst = 1; @(negedge clk); rst = 0;
    chk("rstb_valid", 32'(out_valid), 32'h0);
    chk("rstb_pos", 32'(out_pos), 32'h0);
    chk("rstb_ovr", 32'(ovr), 32'h0);
    repeat (4) @(negedge clk);
    chk("rstb_nobeat", 32'(out_valid), 32'h0);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
